alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds signed/unsigned compare, signed add/sub overflow, and iterative unsigned multiply and divide, which are too slow for a combinational path.
- Sits in the execute stage behind a valid/ready handshake. The pipeline stalls on in_ready/out_valid while a MULU/DIVU is in progress.

---
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops (logic, compares, add/sub, DIVU by zero, reserved opcodes)
// complete one cycle after acceptance. MULU/DIVU iterate one bit per cycle and
// complete WIDTH+1 cycles after acceptance.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_ready   request handshake (op, a, b sampled on acceptance)
//   out_valid, out_ready result handshake (result held until consumed)
//   result_lo, result_hi main result / product / quotient and remainder
//   zero, overflow       result_lo == 0, signed ADD/SUB overflow
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Single-cycle result path
  logic [WIDTH-1:0] sum_c, diff_c, sc_lo_c, sc_hi_c;
  logic             sc_ovf_c;

  always_comb begin
    sum_c    = a + b;
    diff_c   = a - b;
    sc_lo_c  = '0;
    sc_hi_c  = '0;
    sc_ovf_c = 1'b0;
    case (op)
      OP_AND:  sc_lo_c = a & b;
      OP_OR:   sc_lo_c = a | b;
      OP_NOR:  sc_lo_c = ~(a | b);
      OP_SLT:  sc_lo_c = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_SLTU: sc_lo_c = (a < b) ? WIDTH'(1) : '0;
      OP_ADD: begin
        sc_lo_c  = sum_c;
        sc_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo_c  = diff_c;
        sc_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIVU: begin
        // Only reaches this path with b == 0
        sc_lo_c = '1;
        sc_hi_c = a;
      end
      default: ;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide on the work regs
  logic [WIDTH:0]   add_c, shifted_c, trial_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;

  always_comb begin
    add_c     = {1'b0, work_hi_q} + {1'b0, divisor_q};
    shifted_c = {work_hi_q, work_lo_q[WIDTH-1]};
    trial_c   = shifted_c - {1'b0, divisor_q};
    step_hi_c = work_hi_q;
    step_lo_c = work_lo_q;
    if (is_div_q) begin
      // trial_c[WIDTH] set means the shifted remainder was below the divisor
      if (!trial_c[WIDTH]) begin
        step_hi_c = trial_c[WIDTH-1:0];
        step_lo_c = {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_c = shifted_c[WIDTH-1:0];
        step_lo_c = {work_lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (work_lo_q[0]) begin
      step_hi_c = add_c[WIDTH:1];
      step_lo_c = {add_c[0], work_lo_q[WIDTH-1:1]};
    end else begin
      step_hi_c = {1'b0, work_hi_q[WIDTH-1:1]};
      step_lo_c = {work_hi_q[0], work_lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and output registers
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    divisor_d = divisor_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MULU || (op == OP_DIVU && b != '0)) begin
            state_d   = S_BUSY;
            count_d   = '0;
            is_div_d  = (op == OP_DIVU);
            divisor_d = b;
            work_hi_d = '0;
            work_lo_d = a;
          end else begin
            state_d  = S_DONE;
            res_lo_d = sc_lo_c;
            res_hi_d = sc_hi_c;
            ovf_d    = sc_ovf_c;
            zero_d   = (sc_lo_c == '0);
          end
        end
      end
      S_BUSY: begin
        if (count_q == CW'(WIDTH)) begin
          state_d  = S_DONE;
          res_lo_d = work_lo_q;
          res_hi_d = work_hi_q;
          ovf_d    = 1'b0;
          zero_d   = (work_lo_q == '0);
        end else begin
          work_hi_d = step_hi_c;
          work_lo_d = step_lo_c;
          count_d   = count_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      is_div_q    <= 1'b0;
      divisor_q   <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      is_div_q    <= is_div_d;
      divisor_q   <= divisor_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
// Status word compared per vector: {out_valid, zero, overflow, result_hi, result_lo}.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] stat();
    return {out_valid, zero, overflow, result_hi, result_lo};
  endfunction

  // Present one request for exactly one edge; caller ensures in_ready=1
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'hF; a = '0; b = '0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Count edges until out_valid, bounded
  task automatic wait_done(output int n, output int ready_bad);
    n = 0; ready_bad = 0;
    while (!out_valid && n < 60) begin
      if (in_ready) ready_bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tests++;
    if ({in_ready, stat()} !== {1'b1, 67'd0}) begin
      fails++;
      $display("FAIL reset: got rdy=%b stat=%h, exp rdy=1 stat=0", in_ready, stat());
    end
  endtask

  task automatic test_single();
    logic [3:0]  vo [10];
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic [66:0] ve [10];
    vo[0] = 4'd5;  va[0] = 32'h7FFFFFFF; vb[0] = 32'h1;        ve[0] = {3'b101, 32'h0, 32'h80000000};
    vo[1] = 4'd3;  va[1] = 32'hFFFFFFFF; vb[1] = 32'h1;        ve[1] = {3'b100, 32'h0, 32'h1};
    vo[2] = 4'd4;  va[2] = 32'hFFFFFFFF; vb[2] = 32'h1;        ve[2] = {3'b110, 32'h0, 32'h0};
    vo[3] = 4'd6;  va[3] = 32'h5;        vb[3] = 32'h5;        ve[3] = {3'b110, 32'h0, 32'h0};
    vo[4] = 4'd6;  va[4] = 32'h80000000; vb[4] = 32'h1;        ve[4] = {3'b101, 32'h0, 32'h7FFFFFFF};
    vo[5] = 4'd5;  va[5] = 32'hFFFFFFFF; vb[5] = 32'h1;        ve[5] = {3'b110, 32'h0, 32'h0};
    vo[6] = 4'd1;  va[6] = 32'h000000F0; vb[6] = 32'h0000000F; ve[6] = {3'b100, 32'h0, 32'hFF};
    vo[7] = 4'd2;  va[7] = 32'h0;        vb[7] = 32'h0;        ve[7] = {3'b100, 32'h0, 32'hFFFFFFFF};
    vo[8] = 4'd12; va[8] = 32'h1234;     vb[8] = 32'h5678;     ve[8] = {3'b110, 32'h0, 32'h0};
    vo[9] = 4'd8;  va[9] = 32'h1234;     vb[9] = 32'h0;        ve[9] = {3'b100, 32'h1234, 32'hFFFFFFFF};
    for (int i = 0; i < 10; i++) begin
      send(vo[i], va[i], vb[i]);
      tests++;
      if (stat() !== ve[i]) begin
        fails++;
        $display("FAIL single[%0d] op=%0d: got %h, exp %h", i, vo[i], stat(), ve[i]);
      end
      consume();
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
        fails++;
        $display("FAIL single_release[%0d]: got rdy/vld=%b, exp 10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0]  vo [4];
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [66:0] ve [4];
    int n, rb;
    vo[0] = 4'd7; va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ve[0] = {3'b100, 32'hFFFFFFFE, 32'h00000001};
    vo[1] = 4'd8; va[1] = 32'd100;      vb[1] = 32'd7;        ve[1] = {3'b100, 32'd2, 32'd14};
    vo[2] = 4'd7; va[2] = 32'h80000000; vb[2] = 32'h3;        ve[2] = {3'b100, 32'h1, 32'h80000000};
    vo[3] = 4'd8; va[3] = 32'd5;        vb[3] = 32'd9;        ve[3] = {3'b110, 32'd5, 32'd0};
    for (int i = 0; i < 4; i++) begin
      send(vo[i], va[i], vb[i]);
      wait_done(n, rb);
      tests++;
      if (n !== 33 || rb !== 0) begin
        fails++;
        $display("FAIL multi_latency[%0d]: got %0d cycles (ready-high %0d), exp 33 (0)", i, n, rb);
      end
      tests++;
      if (stat() !== ve[i]) begin
        fails++;
        $display("FAIL multi[%0d] op=%0d: got %h, exp %h", i, vo[i], stat(), ve[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n, rb, unstable;
    send(4'd7, 32'h0001_0000, 32'h0001_0000);
    wait_done(n, rb);
    in_valid = 1'b1; op = 4'd0; a = 32'hFF00FF00; b = 32'h0F0F0F0F;
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (stat() !== {3'b110, 32'h1, 32'h0} || in_ready !== 1'b0) unstable++;
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL backpressure_hold: got %0d unstable cycles (stat %h), exp 0", unstable, stat());
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, stat()} !== {1'b1, 3'b010, 32'h1, 32'h0}) begin
      fails++;
      $display("FAIL backpressure_release: got rdy=%b stat=%h, exp rdy=1 stat=%h",
               in_ready, stat(), {3'b010, 32'h1, 32'h0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (stat() !== {3'b100, 32'h0, 32'h0F000F00}) begin
      fails++;
      $display("FAIL backpressure_next: got %h, exp %h", stat(), {3'b100, 32'h0, 32'h0F000F00});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send(4'd8, 32'hDEADBEEF, 32'h3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests++;
    if ({in_ready, stat()} !== {1'b1, 67'd0}) begin
      fails++;
      $display("FAIL reset_mid: got rdy=%b stat=%h, exp rdy=1 stat=0", in_ready, stat());
    end
    send(4'd0, 32'hF0F0, 32'h0FF0);
    tests++;
    if (stat() !== {3'b100, 32'h0, 32'h00F0}) begin
      fails++;
      $display("FAIL reset_mid_and: got %h, exp %h", stat(), {3'b100, 32'h0, 32'h00F0});
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
